// File: rtl/pipe_stage.sv
// Elastic pipeline register with a valid/ready handshake on both sides.
// SKID=0 is a single register whose ready is combinational from out_ready.
// SKID=1 adds a second (skid) register so that in_ready is a flop output.
// Flush discards every held entry. A saturating counter records the cycles
// in which an output is offered and refused.
module pipe_stage #(
    parameter int WIDTH = 108,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Count cycles where the stage offers data and downstream refuses it.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // flop samples the values from before this edge, whatever the order
        // in which the always blocks are evaluated.
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    if (SKID == 0) begin : g_single

        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        // Single entry: load on accept, drop valid on drain or flush.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                // NOTE: the payload register is reset as well, because
                // out_data is defined to read 0 after reset; it never
                // depends on this for correctness, only for observability.
                data_q  <= '0;
            end else begin
                if (in_fire) begin
                    data_q <= in_data;
                end
                if (flush) begin
                    valid_q <= 1'b0;
                end else if (in_fire) begin
                    valid_q <= 1'b1;
                end else if (out_fire) begin
                    valid_q <= 1'b0;
                end
            end
        end

        assign in_ready  = !valid_q || out_ready;
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign occupancy = {1'b0, valid_q};

    end else begin : g_skid

        typedef enum logic [1:0] {
            EMPTY = 2'd0,
            MAIN  = 2'd1,
            BOTH  = 2'd2
        } state_t;

        state_t           state;
        logic             valid_q;
        logic             ready_q;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;

        // Main/skid FSM; out_data is always taken from main, the skid entry
        // only absorbs the word that arrives while ready is still high.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state   <= EMPTY;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
                main_q  <= '0;
                skid_q  <= '0;
            end else if (flush) begin
                state   <= EMPTY;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            main_q  <= in_data;
                            state   <= MAIN;
                            valid_q <= 1'b1;
                        end
                    end
                    MAIN: begin
                        if (in_fire && out_fire) begin
                            main_q <= in_data;
                        end else if (in_fire) begin
                            skid_q  <= in_data;
                            state   <= BOTH;
                            ready_q <= 1'b0;
                        end else if (out_fire) begin
                            state   <= EMPTY;
                            valid_q <= 1'b0;
                        end
                    end
                    BOTH: begin
                        if (out_fire) begin
                            main_q  <= skid_q;
                            state   <= MAIN;
                            ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end

        assign in_ready  = ready_q;
        assign out_valid = valid_q;
        assign out_data  = main_q;
        assign occupancy = 2'(state);

    end

endmodule
